sram_like_slave: RTL and testbench

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

---
 rtl/sram_like_slave_if.sv | 25 ++
 rtl/sram_like_slave.sv | 97 +++++++++
 tb/tb_sram_like_slave.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_slave_if.sv
// SRAM-like request/response bus between a master and sram_like_slave.
// Latency: none, the interface is wiring only.
// Backpressure: addr_ok gates request acceptance; responses are never stalled.
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wdata, stall,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wdata, stall,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/sram_like_slave.sv
// SRAM-like slave: 2^AW x 32-bit memory with byte strobes and a sticky illegal-access flag.
// Latency: data_ok pulses exactly LAT cycles after the acceptance edge, in acceptance order.
// Backpressure: addr_ok drops at MAX_OUT outstanding (or on stall); the response pipe never stalls.
module sram_like_slave #(
  parameter int AW      = 15,
  parameter int LAT     = 2,
  parameter int MAX_OUT = 2
) (
  input logic              clk,
  input logic              rst,
  sram_like_slave_if.slave bus
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic        vld;
    logic        ill;
    logic [31:0] dat;
  } resp_t;

  resp_t          pipe [LAT];
  logic [31:0]    mem  [2**AW];
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  out_eff;
  logic           accept;
  logic           illegal;
  logic [3:0]     be;
  logic [AW-1:0]  widx;

  // Upper address bits are dropped here, so addresses alias modulo 2^(AW+2)
  assign widx = bus.addr[AW+1:2];

  // A response leaving this cycle frees its slot for a new request immediately
  always_comb begin
    out_eff = outstanding - CW'(bus.data_ok);
  end

  assign bus.addr_ok = bus.req & ~bus.stall & ~rst & (out_eff < CW'(MAX_OUT));
  assign accept      = bus.addr_ok;

  // Decode size/alignment legality and the byte-lane strobes
  always_comb begin
    illegal = 1'b0;
    be      = 4'b0000;
    case (bus.size)
      2'd0: be = 4'b0001 << bus.addr[1:0];
      2'd1: begin
        illegal = bus.addr[0];
        be      = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        illegal = (bus.addr[1:0] != 2'b00);
        be      = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Byte-strobed write at the acceptance edge; no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (accept && bus.wr && !illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Response shift pipe, registered outputs, outstanding count and sticky err
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      outstanding <= '0;
      bus.err     <= 1'b0;
      bus.data_ok <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      // Reads sample the word before any later write can land on it
      pipe[0].vld <= accept;
      pipe[0].ill <= accept & illegal;
      pipe[0].dat <= (accept && !bus.wr && !illegal) ? mem[widx] : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];

      bus.data_ok <= pipe[LAT-1].vld;
      bus.rdata   <= (pipe[LAT-1].vld && !pipe[LAT-1].ill) ? pipe[LAT-1].dat : '0;

      case ({accept, bus.data_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (accept && illegal) bus.err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Self-checking bench for sram_like_slave against a queue/array reference model.
// Latency: model expects each response LAT cycles after its acceptance edge.
// Backpressure: model predicts addr_ok from its own pending-response count and stall/rst.
module tb_sram_like_slave;
  localparam int AW      = 15;
  localparam int LAT     = 2;
  localparam int MAX_OUT = 2;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  logic clk;
  logic rst;
  sram_like_slave_if bus();

  sram_like_slave #(.AW(AW), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  exp_t        q[$];
  logic [31:0] mem_m [int];
  logic        err_m = 1'b0;
  logic        last_acc = 1'b0;
  logic        last_aok = 1'b0;
  logic [31:0] last_rd  = '0;
  int          dok_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour of one accepted request
  task automatic model_accept();
    int          w;
    logic        ill;
    logic [31:0] word;
    logic [1:0]  lo;
    exp_t        e;
    w   = int'(bus.addr[AW+1:2]);
    lo  = bus.addr[1:0];
    ill = (bus.size == 2'd3) || (bus.size == 2'd1 && lo[0]) || (bus.size == 2'd2 && lo != 2'd0);
    e.due = cyc + LAT + 1;
    e.dat = '0;
    if (ill) begin
      err_m = 1'b1;
    end else if (bus.wr) begin
      word = mem_m.exists(w) ? mem_m[w] : 32'h0;
      for (int lane = 0; lane < 4; lane++) begin
        if ((bus.size == 2'd2) ||
            (bus.size == 2'd1 && lane / 2 == int'(lo) / 2) ||
            (bus.size == 2'd0 && lane == int'(lo)))
          word[8*lane +: 8] = bus.wdata[8*lane +: 8];
      end
      mem_m[w] = word;
    end else begin
      e.dat = mem_m.exists(w) ? mem_m[w] : 32'hxxxx_xxxx;
    end
    q.push_back(e);
  endtask

  // One clock cycle: compare outputs with the model, then advance the model
  task automatic cycle();
    logic exp_dok;
    logic exp_aok;
    int   cnt;
    @(negedge clk);
    exp_dok = (q.size() > 0) && (q[0].due == cyc);
    check("data_ok", {31'b0, bus.data_ok}, {31'b0, exp_dok});
    if (exp_dok) check("rdata", bus.rdata, q[0].dat);
    check("err", {31'b0, bus.err}, {31'b0, err_m});
    cnt     = q.size() - (exp_dok ? 1 : 0);
    exp_aok = bus.req && !bus.stall && !rst && (cnt < MAX_OUT);
    check("addr_ok", {31'b0, bus.addr_ok}, {31'b0, exp_aok});
    last_aok = bus.addr_ok;
    if (bus.data_ok) begin
      last_rd = bus.rdata;
      dok_cnt++;
    end
    if (exp_dok) void'(q.pop_front());
    if (rst) begin
      q.delete();
      err_m    = 1'b0;
      last_acc = 1'b0;
    end else begin
      last_acc = exp_aok;
      if (exp_aok) model_accept();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.addr = a; bus.wdata = d;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    check("issue_accepted", {31'b0, last_acc}, 32'd1);
    bus.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        aok_hist [12];
    logic        stall_aok;
    int          acc_cnt;
    logic [31:0] a;

    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.addr = '0; bus.wdata = '0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset still high with a request pending: nothing may be accepted
    bus.req = 1'b1;
    cycle();
    check("reset_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    bus.req = 1'b0;

    // Word write then immediate read of the same word
    issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    idle(5);
    check("raw_word", last_rd, 32'hDEADBEEF);

    // Byte merge into an existing word
    issue(1'b1, 2'd2, 32'h10, 32'h11223344);
    issue(1'b1, 2'd0, 32'h13, 32'hAA000000);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    idle(5);
    check("byte_merge", last_rd, 32'hAA223344);

    // Initialise the random-phase pool and word 0x20
    for (int k = 0; k < 8; k++) issue(1'b1, 2'd2, 32'h100 + 32'(4 * k), $urandom);
    issue(1'b1, 2'd2, 32'h20, 32'h55667788);
    idle(4);

    // Four back-to-back reads with req held: addr_ok pattern and ordering
    dok_cnt = 0;
    acc_cnt = 0;
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h100;
    for (int k = 0; k < 12; k++) begin
      cycle();
      aok_hist[k] = last_aok;
      if (last_acc) begin
        acc_cnt++;
        bus.addr = 32'h100 + 32'(4 * acc_cnt);
        if (acc_cnt == 4) bus.req = 1'b0;
      end
    end
    check("burst_aok_c0", {31'b0, aok_hist[0]}, 32'd1);
    check("burst_aok_c1", {31'b0, aok_hist[1]}, 32'd1);
    check("burst_aok_c2", {31'b0, aok_hist[2]}, 32'd0);
    check("burst_aok_c3", {31'b0, aok_hist[3]}, 32'd1);
    check("burst_dok_count", 32'(dok_cnt), 32'd4);

    // Misaligned half write: err, zero response, memory untouched
    issue(1'b1, 2'd1, 32'h21, 32'hFFFFFFFF);
    idle(4);
    check("err_half", {31'b0, bus.err}, 32'd1);
    issue(1'b0, 2'd2, 32'h20, 32'h0);
    idle(5);
    check("half_ill_unchanged", last_rd, 32'h55667788);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Stall blocks acceptance; release accepts on the first low cycle
    stall_aok = 1'b0;
    bus.stall = 1'b1; bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h104;
    repeat (3) begin
      cycle();
      stall_aok = stall_aok | last_aok;
    end
    check("stall_block", {31'b0, stall_aok}, 32'd0);
    bus.stall = 1'b0;
    cycle();
    check("stall_release", {31'b0, last_aok}, 32'd1);
    idle(5);

    // Aliasing above AW+1
    issue(1'b1, 2'd2, 32'hF002_0010, 32'h13579BDF);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    idle(5);
    check("alias", last_rd, 32'h13579BDF);

    // Reset right after a write: response dropped, data kept
    issue(1'b1, 2'd2, 32'h30, 32'hCAFEF00D);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    dok_cnt = 0;
    idle(6);
    check("rst_no_dok", 32'(dok_cnt), 32'd0);
    issue(1'b0, 2'd2, 32'h30, 32'h0);
    idle(5);
    check("rst_keep", last_rd, 32'hCAFEF00D);

    // Randomised traffic over the initialised pool
    for (int k = 0; k < 400; k++) begin
      a = $urandom;
      a[AW+1:2] = AW'(32'h40 + $urandom_range(0, 7));
      bus.addr  = a;
      bus.req   = ($urandom_range(0, 3) != 0);
      bus.wr    = $urandom_range(0, 1) == 1;
      bus.size  = 2'($urandom_range(0, 3));
      bus.wdata = $urandom;
      bus.stall = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.stall = 1'b0;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
